// File: rtl/gpu_pkg.sv
// Shared GPU types: per-warp scheduler state and the instruction memory address.
package gpu_pkg;

    localparam int IMEM_ADDR_W = 8;

    typedef logic [IMEM_ADDR_W-1:0] instruction_memory_address_t;

    typedef enum logic [2:0] {
        WARP_IDLE,
        WARP_FETCH,
        WARP_READY,
        WARP_EXEC,
        WARP_HALTED
    } warp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one requester, searching upward from pointer with wrap.
// Latency: combinational. Backpressure: grant_enable low forces grant to 0.
// Owner of fairness only; the caller advances the pointer after a grant is consumed.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    input  logic          grant_enable,
    output logic [IW-1:0] grant
);

    int idx;

    // Walk offsets from far to near so the requester closest to the pointer wins.
    always_comb begin
        grant = '0;
        idx   = 0;
        if (grant_enable) begin
            for (int i = N - 1; i >= 0; i--) begin
                idx = int'(pointer) + i;
                if (idx >= N) idx = idx - N;
                if (req[idx]) grant = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Per-warp fetch/issue/complete sequencing with a single round-robin issue port.
// Latency: start->fetch_valid 1, fetch_ready->issue_valid 1, complete->fetch_valid 1 cycle.
// Backpressure: issue_ready low freezes the offered warp/pc in a hold register.
module warp_scheduler
    import gpu_pkg::*;
#(
    parameter int   WARPS_PER_CORE = 4,
    parameter int   PC_WIDTH       = IMEM_ADDR_W,
    localparam int  WID            = (WARPS_PER_CORE > 1) ? $clog2(WARPS_PER_CORE) : 1,
    localparam int  NW             = $clog2(WARPS_PER_CORE + 1)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [PC_WIDTH-1:0]                      start_pc,
    input  logic [NW-1:0]                            num_warps,
    output logic                                     done,
    output logic [WARPS_PER_CORE-1:0]                fetch_valid,
    output logic [WARPS_PER_CORE-1:0][PC_WIDTH-1:0]  fetch_pc,
    input  logic [WARPS_PER_CORE-1:0]                fetch_ready,
    input  logic [WARPS_PER_CORE-1:0]                fetch_is_halt,
    output logic                                     issue_valid,
    output logic [WID-1:0]                           issue_warp,
    output logic [PC_WIDTH-1:0]                      issue_pc,
    input  logic                                     issue_ready,
    input  logic                                     complete_valid,
    input  logic [WID-1:0]                           complete_warp,
    input  logic [PC_WIDTH-1:0]                      complete_next_pc,
    output logic [WARPS_PER_CORE-1:0]                warp_active,
    output logic [31:0]                              issue_count,
    output logic                                     protocol_error
);

    warp_state_t               state_q [WARPS_PER_CORE];
    warp_state_t               state_d [WARPS_PER_CORE];
    logic [PC_WIDTH-1:0]       pc_q    [WARPS_PER_CORE];
    logic [PC_WIDTH-1:0]       pc_d    [WARPS_PER_CORE];

    logic [WID-1:0]            rr_ptr;
    logic [WID-1:0]            hold_warp;
    logic                      hold_vld;
    logic [WID-1:0]            grant;
    logic [WID-1:0]            sel_warp;
    logic [WARPS_PER_CORE-1:0] ready_vec;
    logic                      all_halted;
    logic                      cmpl_hit;
    logic                      start_acc;
    logic                      handshake;
    logic [NW-1:0]             nw_eff;

    assign nw_eff = (int'(num_warps) > WARPS_PER_CORE) ? NW'(WARPS_PER_CORE) : num_warps;

    always_comb begin
        ready_vec   = '0;
        warp_active = '0;
        fetch_valid = '0;
        fetch_pc    = '0;
        all_halted  = 1'b1;
        cmpl_hit    = 1'b0;
        for (int w = 0; w < WARPS_PER_CORE; w++) begin
            ready_vec[w]   = (state_q[w] == WARP_READY);
            fetch_valid[w] = (state_q[w] == WARP_FETCH);
            warp_active[w] = (state_q[w] == WARP_FETCH) || (state_q[w] == WARP_READY) ||
                             (state_q[w] == WARP_EXEC);
            if (state_q[w] == WARP_FETCH) fetch_pc[w] = pc_q[w];
            if (state_q[w] != WARP_HALTED) all_halted = 1'b0;
            // An out-of-range complete_warp never matches, so it is flagged below.
            if (complete_valid && state_q[w] == WARP_EXEC && complete_warp == WID'(w))
                cmpl_hit = 1'b1;
        end
    end

    rr_arbiter #(
        .N  (WARPS_PER_CORE),
        .IW (WID)
    ) u_rr_arbiter (
        .req          (ready_vec),
        .pointer      (rr_ptr),
        .grant_enable (~hold_vld),
        .grant        (grant)
    );

    assign sel_warp    = hold_vld ? hold_warp : grant;
    assign issue_valid = hold_vld | (|ready_vec);
    assign handshake   = issue_valid & issue_ready;
    assign start_acc   = start & ~(|warp_active);

    always_comb begin
        issue_warp = '0;
        issue_pc   = '0;
        if (issue_valid) begin
            issue_warp = sel_warp;
            for (int w = 0; w < WARPS_PER_CORE; w++)
                if (sel_warp == WID'(w)) issue_pc = pc_q[w];
        end
    end

    always_comb begin
        for (int w = 0; w < WARPS_PER_CORE; w++) begin
            state_d[w] = state_q[w];
            pc_d[w]    = pc_q[w];
            if (start_acc) begin
                if (w < int'(nw_eff)) begin
                    state_d[w] = WARP_FETCH;
                    pc_d[w]    = start_pc;
                end else begin
                    state_d[w] = WARP_HALTED;
                end
            end else begin
                case (state_q[w])
                    WARP_FETCH:
                        if (fetch_ready[w])
                            state_d[w] = fetch_is_halt[w] ? WARP_HALTED : WARP_READY;
                    WARP_READY:
                        if (handshake && sel_warp == WID'(w)) state_d[w] = WARP_EXEC;
                    WARP_EXEC:
                        if (complete_valid && complete_warp == WID'(w)) begin
                            state_d[w] = WARP_FETCH;
                            pc_d[w]    = complete_next_pc;
                        end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < WARPS_PER_CORE; w++) begin
                state_q[w] <= WARP_IDLE;
                pc_q[w]    <= '0;
            end
            done           <= 1'b0;
            issue_count    <= '0;
            protocol_error <= 1'b0;
            rr_ptr         <= '0;
            hold_vld       <= 1'b0;
            hold_warp      <= '0;
        end else begin
            for (int w = 0; w < WARPS_PER_CORE; w++) begin
                state_q[w] <= state_d[w];
                pc_q[w]    <= pc_d[w];
            end
            if (start_acc) begin
                done           <= 1'b0;
                issue_count    <= '0;
                protocol_error <= 1'b0;
                rr_ptr         <= '0;
                hold_vld       <= 1'b0;
            end else begin
                done <= all_halted;
                if (complete_valid && !cmpl_hit) protocol_error <= 1'b1;
                if (handshake) begin
                    hold_vld <= 1'b0;
                    rr_ptr   <= (int'(sel_warp) == WARPS_PER_CORE - 1) ? '0 : sel_warp + WID'(1);
                    if (issue_count != '1) issue_count <= issue_count + 32'd1;
                end else if (issue_valid && !hold_vld) begin
                    // Freeze the offer so a newly READY warp cannot displace it.
                    hold_vld  <= 1'b1;
                    hold_warp <= grant;
                end
            end
        end
    end

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed table plus hand sequences for warp_scheduler with 4 warps and 8-bit pcs.
module tb_warp_scheduler;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [7:0]       start_pc;
    logic [2:0]       num_warps;
    logic             done;
    logic [3:0]       fetch_valid;
    logic [3:0][7:0]  fetch_pc;
    logic [3:0]       fetch_ready;
    logic [3:0]       fetch_is_halt;
    logic             issue_valid;
    logic [1:0]       issue_warp;
    logic [7:0]       issue_pc;
    logic             issue_ready;
    logic             complete_valid;
    logic [1:0]       complete_warp;
    logic [7:0]       complete_next_pc;
    logic [3:0]       warp_active;
    logic [31:0]      issue_count;
    logic             protocol_error;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    warp_scheduler #(.WARPS_PER_CORE(4), .PC_WIDTH(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .start_pc         (start_pc),
        .num_warps        (num_warps),
        .done             (done),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .fetch_ready      (fetch_ready),
        .fetch_is_halt    (fetch_is_halt),
        .issue_valid      (issue_valid),
        .issue_warp       (issue_warp),
        .issue_pc         (issue_pc),
        .issue_ready      (issue_ready),
        .complete_valid   (complete_valid),
        .complete_warp    (complete_warp),
        .complete_next_pc (complete_next_pc),
        .warp_active      (warp_active),
        .issue_count      (issue_count),
        .protocol_error   (protocol_error)
    );

    typedef struct {
        logic       start;
        logic [2:0] nw;
        logic [3:0] fr;
        logic [3:0] fh;
        logic       ir;
        logic       cv;
        logic [1:0] cw;
        logic [7:0] cpc;
        logic [3:0] e_fv;
        logic [7:0] e_fpc0;
        logic       e_iv;
        logic [1:0] e_iw;
        logic [7:0] e_ipc;
        logic [3:0] e_act;
        logic       e_done;
        int         e_cnt;
        logic       e_err;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; fetch_ready = '0; fetch_is_halt = '0;
        issue_ready = 1'b0; complete_valid = 1'b0; complete_warp = '0; complete_next_pc = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " fetch_valid"}, 32'(fetch_valid), 0);
        chk({tag, " fetch_pc"},    fetch_pc,         0);
        chk({tag, " issue_valid"}, 32'(issue_valid), 0);
        chk({tag, " issue_warp"},  32'(issue_warp),  0);
        chk({tag, " issue_pc"},    32'(issue_pc),    0);
        chk({tag, " warp_active"}, 32'(warp_active), 0);
        chk({tag, " done"},        32'(done),        0);
        chk({tag, " issue_count"}, issue_count,      0);
        chk({tag, " prot_err"},    32'(protocol_error), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        start = v.start; num_warps = v.nw; start_pc = 8'h10;
        fetch_ready = v.fr; fetch_is_halt = v.fh; issue_ready = v.ir;
        complete_valid = v.cv; complete_warp = v.cw; complete_next_pc = v.cpc;
        #1;
        chk($sformatf("row%0d fetch_valid", idx), 32'(fetch_valid), 32'(v.e_fv));
        chk($sformatf("row%0d fetch_pc0", idx),   32'(fetch_pc[0]), 32'(v.e_fpc0));
        chk($sformatf("row%0d issue_valid", idx), 32'(issue_valid), 32'(v.e_iv));
        chk($sformatf("row%0d issue_warp", idx),  32'(issue_warp),  32'(v.e_iw));
        chk($sformatf("row%0d issue_pc", idx),    32'(issue_pc),    32'(v.e_ipc));
        chk($sformatf("row%0d warp_active", idx), 32'(warp_active), 32'(v.e_act));
        chk($sformatf("row%0d done", idx),        32'(done),        32'(v.e_done));
        chk($sformatf("row%0d issue_count", idx), issue_count,      32'(v.e_cnt));
        chk($sformatf("row%0d prot_err", idx),    32'(protocol_error), 32'(v.e_err));
    endtask

    initial begin
        // Each row: inputs for the coming edge; expectations describe the state before it.
        //          st nw fr    fh    ir cv cw cpc     fv    fpc0   iv iw ipc    act   dn cnt er
        vecs[0]  = '{1, 4, 4'h0, 4'h0, 0, 0, 0, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0};
        vecs[1]  = '{0, 0, 4'h0, 4'h0, 0, 0, 0, 8'h00, 4'hF, 8'h10, 0, 0, 8'h00, 4'hF, 0, 0, 0};
        vecs[2]  = '{0, 0, 4'hF, 4'h0, 0, 0, 0, 8'h00, 4'hF, 8'h10, 0, 0, 8'h00, 4'hF, 0, 0, 0};
        vecs[3]  = '{0, 0, 4'h0, 4'h0, 1, 0, 0, 8'h00, 4'h0, 8'h00, 1, 0, 8'h10, 4'hF, 0, 0, 0};
        vecs[4]  = '{0, 0, 4'h0, 4'h0, 1, 0, 0, 8'h00, 4'h0, 8'h00, 1, 1, 8'h10, 4'hF, 0, 1, 0};
        vecs[5]  = '{0, 0, 4'h0, 4'h0, 1, 0, 0, 8'h00, 4'h0, 8'h00, 1, 2, 8'h10, 4'hF, 0, 2, 0};
        vecs[6]  = '{0, 0, 4'h0, 4'h0, 1, 0, 0, 8'h00, 4'h0, 8'h00, 1, 3, 8'h10, 4'hF, 0, 3, 0};
        vecs[7]  = '{0, 0, 4'h0, 4'h0, 0, 1, 0, 8'h20, 4'h0, 8'h00, 0, 0, 8'h00, 4'hF, 0, 4, 0};
        vecs[8]  = '{0, 0, 4'h1, 4'h1, 0, 1, 1, 8'h30, 4'h1, 8'h20, 0, 0, 8'h00, 4'hF, 0, 4, 0};
        vecs[9]  = '{0, 0, 4'h2, 4'h2, 0, 1, 2, 8'h40, 4'h2, 8'h00, 0, 0, 8'h00, 4'hE, 0, 4, 0};
        vecs[10] = '{0, 0, 4'h4, 4'h4, 0, 1, 3, 8'h50, 4'h4, 8'h00, 0, 0, 8'h00, 4'hC, 0, 4, 0};
        vecs[11] = '{0, 0, 4'h8, 4'h8, 0, 0, 0, 8'h00, 4'h8, 8'h00, 0, 0, 8'h00, 4'h8, 0, 4, 0};
        vecs[12] = '{0, 0, 4'h0, 4'h0, 0, 0, 0, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 4, 0};
        vecs[13] = '{0, 0, 4'h0, 4'h0, 0, 0, 0, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 4'h0, 1, 4, 0};
        vecs[14] = '{1, 1, 4'h0, 4'h0, 0, 0, 0, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 4'h0, 1, 4, 0};
        vecs[15] = '{0, 0, 4'h0, 4'h0, 0, 0, 0, 8'h00, 4'h1, 8'h10, 0, 0, 8'h00, 4'h1, 0, 0, 0};

        reset = 1'b0; num_warps = '0; start_pc = '0;
        idle_inputs();
        #2 chk_reset_outputs("init");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) apply_vec(vecs[i], i);

        // Stalled offer of warp 1 must not be displaced by warps 0/2 becoming READY.
        do_reset();
        @(negedge clk); idle_inputs(); start = 1'b1; num_warps = 3'd3; start_pc = 8'h40;
        @(negedge clk); start = 1'b0; fetch_ready = 4'b0010;
        #1 chk("hold fetch_valid", 32'(fetch_valid), 32'h7);
        @(negedge clk); fetch_ready = 4'b0101; issue_ready = 1'b0;
        #1 chk("hold first warp", 32'(issue_warp), 1);
        chk("hold first pc", 32'(issue_pc), 32'h40);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); fetch_ready = '0;
            #1 chk($sformatf("hold stall%0d valid", i), 32'(issue_valid), 1);
            chk($sformatf("hold stall%0d warp", i), 32'(issue_warp), 1);
            chk($sformatf("hold stall%0d pc", i), 32'(issue_pc), 32'h40);
        end
        @(negedge clk); issue_ready = 1'b1;
        #1 chk("hold accept warp", 32'(issue_warp), 1);
        @(negedge clk);
        #1 chk("rr next warp", 32'(issue_warp), 2);
        @(negedge clk);
        #1 chk("rr wrap warp", 32'(issue_warp), 0);
        @(negedge clk); issue_ready = 1'b0;
        #1 chk("rr drained valid", 32'(issue_valid), 0);
        chk("rr issue_count", issue_count, 3);

        // Completion for a READY warp is flagged and ignored; start while busy is ignored.
        do_reset();
        @(negedge clk); idle_inputs(); start = 1'b1; num_warps = 3'd4; start_pc = 8'h08;
        @(negedge clk); start = 1'b0; fetch_ready = 4'b1000;
        #1 chk("perr fetch_valid", 32'(fetch_valid), 32'hF);
        @(negedge clk); fetch_ready = '0; complete_valid = 1'b1; complete_warp = 2'd3;
        complete_next_pc = 8'h99;
        #1 chk("perr before", 32'(protocol_error), 0);
        chk("perr offer warp", 32'(issue_warp), 3);
        @(negedge clk); complete_valid = 1'b0; start = 1'b1; num_warps = 3'd1;
        #1 chk("perr flagged", 32'(protocol_error), 1);
        chk("perr still ready", 32'(issue_valid), 1);
        chk("perr ready warp", 32'(issue_warp), 3);
        chk("perr active", 32'(warp_active), 32'hF);
        @(negedge clk); start = 1'b0; issue_ready = 1'b1;
        #1 chk("busy start ignored", 32'(fetch_valid), 32'h7);
        @(negedge clk); issue_ready = 1'b0; complete_valid = 1'b1; complete_warp = 2'd3;
        #1 chk("perr exec valid", 32'(issue_valid), 0);
        @(negedge clk); complete_valid = 1'b0;
        #1 chk("perr refetch", 32'(fetch_valid), 32'hF);
        chk("perr refetch pc", 32'(fetch_pc[3]), 32'h99);
        chk("perr sticky", 32'(protocol_error), 1);

        // Both warps halt on first fetch.
        do_reset();
        @(negedge clk); idle_inputs(); start = 1'b1; num_warps = 3'd2; start_pc = 8'h20;
        @(negedge clk); start = 1'b0; fetch_ready = 4'b0011; fetch_is_halt = 4'b0011;
        #1 chk("halt fetch_valid", 32'(fetch_valid), 32'h3);
        @(negedge clk); fetch_ready = '0; fetch_is_halt = '0;
        #1 chk("halt active", 32'(warp_active), 0);
        chk("halt done early", 32'(done), 0);
        @(negedge clk);
        #1 chk("halt done", 32'(done), 1);
        chk("halt issue_valid", 32'(issue_valid), 0);

        // Reset mid-block with a pending held offer, then relaunch one warp.
        do_reset();
        @(negedge clk); idle_inputs(); start = 1'b1; num_warps = 3'd2; start_pc = 8'h33;
        @(negedge clk); start = 1'b0; fetch_ready = 4'b0001;
        @(negedge clk); fetch_ready = 4'b0010; issue_ready = 1'b1;
        #1 chk("mid issue w0", 32'(issue_warp), 0);
        @(negedge clk); fetch_ready = '0; issue_ready = 1'b0;
        #1 chk("mid offer w1", 32'(issue_warp), 1);
        chk("mid active", 32'(warp_active), 32'h3);
        do_reset();
        #1 chk("post reset issue_valid", 32'(issue_valid), 0);
        @(negedge clk); start = 1'b1; num_warps = 3'd1; start_pc = 8'h77;
        #1 chk("relaunch no stale", 32'(issue_valid), 0);
        @(negedge clk); start = 1'b0; fetch_ready = 4'b0001;
        #1 chk("relaunch fetch_valid", 32'(fetch_valid), 32'h1);
        chk("relaunch fetch_pc0", 32'(fetch_pc[0]), 32'h77);
        @(negedge clk); fetch_ready = '0;
        #1 chk("relaunch issue warp", 32'(issue_warp), 0);
        chk("relaunch issue pc", 32'(issue_pc), 32'h77);

        // Oversized num_warps clamps to the core size.
        do_reset();
        @(negedge clk); idle_inputs(); start = 1'b1; num_warps = 3'd7; start_pc = 8'h55;
        @(negedge clk); start = 1'b0;
        #1 chk("clamp fetch_valid", 32'(fetch_valid), 32'hF);
        chk("clamp fetch_pc0", 32'(fetch_pc[0]), 32'h55);

        // Empty block completes two cycles after start.
        do_reset();
        @(negedge clk); idle_inputs(); start = 1'b1; num_warps = 3'd0; start_pc = 8'h01;
        @(negedge clk); start = 1'b0;
        #1 chk("empty done +1", 32'(done), 0);
        chk("empty fetch_valid", 32'(fetch_valid), 0);
        @(negedge clk);
        #1 chk("empty done +2", 32'(done), 1);
        chk("empty issue_valid", 32'(issue_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/warp_scheduler.md
WARP_SCHEDULER -- requirements
Module: warp_scheduler

Interface
REQ-001 SHALL have parameter WARPS_PER_CORE, default 4, number of warp slots (legal 1..16).
REQ-002 SHALL have parameter PC_WIDTH, default 8, width of instruction_memory_address_t.
REQ-003 SHALL define WID = max(1, $clog2(WARPS_PER_CORE)) and NW = $clog2(WARPS_PER_CORE+1).
REQ-004 SHALL have ports, in order:
- clk  input  1  sole clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  block launch pulse.
- start_pc  input  PC_WIDTH  initial PC for all launched warps.
- num_warps  input  NW  warps launched; values above WARPS_PER_CORE are treated as WARPS_PER_CORE.
- done  output  1  block complete.
- fetch_valid  output  WARPS_PER_CORE  per-warp fetch request.
- fetch_pc  output  PC_WIDTH x WARPS_PER_CORE  per-warp fetch address.
- fetch_ready  input  WARPS_PER_CORE  per-warp instruction returned.
- fetch_is_halt  input  WARPS_PER_CORE  decoded HALT flag, qualified by fetch_ready.
- issue_valid  output  1  instruction offered to the execution unit.
- issue_warp  output  WID  warp offered.
- issue_pc  output  PC_WIDTH  PC of the offered instruction.
- issue_ready  input  1  execution unit accepts.
- complete_valid  input  1  execution finished.
- complete_warp  input  WID  warp finished.
- complete_next_pc  input  PC_WIDTH  next PC for that warp.
- warp_active  output  WARPS_PER_CORE  warp in FETCH, READY or EXEC.
- issue_count  output  32  handshakes this block, saturating.
- protocol_error  output  1  sticky error flag.

Function
REQ-005 SHALL keep one state per warp: IDLE, FETCH, READY, EXEC, HALTED.
REQ-006 SHALL, on start while idle or done, set warps w < num_warps to FETCH with pc = start_pc and all others to HALTED, clear done, issue_count and protocol_error, and reset the round-robin pointer to warp 0.
REQ-007 SHALL ignore start while any warp is in FETCH, READY or EXEC.
REQ-008 SHALL drive fetch_valid[w] = 1 and fetch_pc[w] = pc[w] exactly while warp w is in FETCH.
REQ-009 SHALL, in FETCH on fetch_ready[w], move the warp to HALTED if fetch_is_halt[w] is set, else to READY.
REQ-010 SHALL assert issue_valid combinationally whenever a warp is READY or the issue hold register is loaded.
REQ-011 SHALL choose among READY warps round-robin, starting at the warp after the last granted warp.
REQ-012 SHALL hold issue_warp and issue_pc stable from first issue_valid until the handshake, even if other warps become READY.
REQ-013 SHALL, on handshake (issue_valid && issue_ready), move the warp to EXEC, advance the pointer, and increment issue_count saturating at 2^32-1.
REQ-014 SHALL, in EXEC on complete_valid with matching complete_warp, set pc = complete_next_pc and return the warp to FETCH.
REQ-015 SHALL accept a completion and a handshake for different warps in the same cycle.
REQ-016 SHALL set protocol_error on complete_valid for a warp not in EXEC or on complete_warp >= WARPS_PER_CORE, and SHALL ignore that completion.
REQ-017 SHALL register done high one cycle after all warps are HALTED following a start, and hold it until the next accepted start.
REQ-018 SHALL give latencies: start to fetch_valid 1 cycle; fetch_ready to issue_valid 1 cycle; completion to fetch_valid 1 cycle.
REQ-019 SHALL, with num_warps = 0, raise done 2 cycles after start and never assert issue_valid.

Reset
REQ-020 SHALL, while reset is low, hold all warps IDLE, all pc = 0, done = 0, fetch_valid = 0, issue_valid = 0, issue_warp = 0, issue_pc = 0, warp_active = 0, issue_count = 0, protocol_error = 0, and the pointer at 0.
REQ-021 SHALL abandon any in-flight block on reset assertion mid-operation, with no pending issue retained after release.

Structure
REQ-022 SHALL take warp_state_t (the five states) and instruction_memory_address_t from the shared gpu package.
REQ-023 SHALL place round-robin selection in one sub-module, rr_arbiter, parameterised by requester count, with inputs req, pointer and grant_enable, and output grant index.

Verification
REQ-024 SHALL cover: num_warps=4, start_pc=0x10, all fetch_ready at once -> issues in warp order 0,1,2,3 with issue_pc=0x10, issue_count=4.
REQ-025 SHALL cover: issue_ready low for 5 cycles while warp 2 becomes READY behind warp 1 -> issue_warp stays 1 until the handshake.
REQ-026 SHALL cover: complete_valid for warp 3 while warp 3 is READY -> protocol_error=1 and warp 3 remains READY.
REQ-027 SHALL cover: num_warps=2, both warps return fetch_is_halt=1 -> done=1 one cycle later and warp_active=0.
REQ-028 SHALL cover: reset driven low while warp 0 is in EXEC, then start with num_warps=1 -> fetch_pc[0]=start_pc and no stale issue.
REQ-029 SHALL cover: num_warps=7 with WARPS_PER_CORE=4 -> exactly 4 warps launched.
